// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte write into data_recv, byte/burst read from data_send.
// Latency: conditions seen 3 clk after the pins (5 clk with I2C_SLAVE_GLITCH_FILTER_EN); outputs registered.
// Backpressure: none; the controller paces every bit on SCL and this block never stretches the clock.
//
// Ports:
//   clk            system clock, must run at least 16x the SCL rate
//   arst           asynchronous active-high reset
//   scl            I2C clock input (never driven)
//   sda            open-drain data line (driven 0 or high-Z only)
//   data_send      byte to transmit on a read, captured in the cycle before tx_load is seen high
//   tx_load        one-clk pulse: data_send has just been captured
//   data_recv      last byte received on a write
//   data_recv_done one-clk pulse, data_recv valid in the same cycle
//   rw             R/W bit of the last matched address byte (1 = read)
//   busy           high from an address match until STOP or a non-matching address byte
//
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchronizer.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_send,
  output logic       tx_load,
  output logic [7:0] data_recv,
  output logic       data_recv_done,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SACK1 = 3'd2,
    WR    = 3'd3,
    SACK2 = 3'd4,
    RD    = 3'd5,
    MACK  = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers, optional majority filter
  // ---------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q;
  logic sda_s1_q, sda_s2_q;
  logic scl_c, sda_c;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Majority over the current and two previous synchronized samples, then
  // registered: a 1-clk pulse never wins the vote, and steady changes arrive
  // 2 clk later than without the filter.
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;
  logic       scl_flt_d, sda_flt_d;

  always_comb begin
    scl_flt_d = (scl_s2_q & scl_hist_q[0]) | (scl_s2_q & scl_hist_q[1]) |
                (scl_hist_q[0] & scl_hist_q[1]);
    sda_flt_d = (sda_s2_q & sda_hist_q[0]) | (sda_s2_q & sda_hist_q[1]) |
                (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s2_q};
      sda_hist_q <= {sda_hist_q[0], sda_s2_q};
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_s2_q;
  assign sda_c = sda_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Edge and bus-condition detection on the conditioned lines
  // ---------------------------------------------------------------------------
  logic scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  // SCL must be high on both samples so an SCL edge coinciding with an SDA
  // change is never mistaken for START/STOP.
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;     // first seven bits of the byte in flight
  logic [7:0]  tx_q, tx_d;           // read byte, MSB presented next
  logic        sda_oe_q, sda_oe_d;   // 1 = pull SDA low
  logic [7:0]  data_recv_q, data_recv_d;
  logic        done_q, done_d;
  logic        tx_load_q, tx_load_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic [7:0]  new_byte;

  assign new_byte = {shift_q, sda_c};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    sda_oe_d    = sda_oe_q;
    data_recv_d = data_recv_q;
    done_d      = 1'b0;
    tx_load_d   = 1'b0;
    rw_d        = rw_q;
    busy_d      = busy_q;

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Ignore everything until the next START.
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d = new_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (new_byte[7:1] == SLAVE_ADDR) begin
                rw_d    = new_byte[0];
                busy_d  = 1'b1;
                state_d = SACK1;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt 0: waiting for the fall that ends bit 8; 1: ACK being driven.
        SACK1: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else if (rw_q) begin
              // The fall that ends the ACK also presents the first read bit.
              tx_load_d = 1'b1;
              sda_oe_d  = ~data_send[7];
              tx_d      = {data_send[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = RD;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR;
            end
          end
        end

        WR: begin
          if (scl_rise) begin
            shift_d = new_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
              data_recv_d = new_byte;
              done_d      = 1'b1;
              bit_cnt_d   = 4'd0;
              state_d     = SACK2;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        SACK2: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR;
            end
          end
        end

        // bit_cnt counts bits already presented on SDA.
        RD: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = MACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // bit_cnt 0: waiting for the controller's ACK/NACK; 1: ACK seen.
        MACK: begin
          if (bit_cnt_q == 4'd0) begin
            if (scl_rise) begin
              if (!sda_c) bit_cnt_d = 4'd1;
              else        state_d   = IDLE;
            end
          end else if (scl_fall) begin
            tx_load_d = 1'b1;
            sda_oe_d  = ~data_send[7];
            tx_d      = {data_send[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = RD;
          end
        end

        default: begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      sda_oe_q    <= 1'b0;
      data_recv_q <= 8'd0;
      done_q      <= 1'b0;
      tx_load_q   <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      sda_oe_q    <= sda_oe_d;
      data_recv_q <= data_recv_d;
      done_q      <= done_d;
      tx_load_q   <= tx_load_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
    end
  end

  // Open drain: only ever pull low; the async reset clears sda_oe_q at once.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign tx_load        = tx_load_q;
  assign data_recv      = data_recv_q;
  assign data_recv_done = done_q;
  assign rw             = rw_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C controller driving i2c_slave with directed and random transfers.
// Expected acks, bytes and pulse counts come from address-match and byte-list rules.
// Every comparison goes through check(); one summary line at the end.
module tb_i2c_slave;

  localparam int Q = 8;  // quarter SCL period in clk cycles (SCL = clk/32)

  logic       clk       = 1'b0;
  logic       arst      = 1'b1;
  logic       scl_drv   = 1'b1;
  logic       tb_sda_oe = 1'b0;
  logic [7:0] data_send = 8'h00;
  wire        sda;
  wire        tx_load;
  wire  [7:0] data_recv;
  wire        data_recv_done;
  wire        rw;
  wire        busy;

  assign sda = tb_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk            (clk),
    .arst           (arst),
    .scl            (scl_drv),
    .sda            (sda),
    .data_send      (data_send),
    .tx_load        (tx_load),
    .data_recv      (data_recv),
    .data_recv_done (data_recv_done),
    .rw             (rw),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: pulse counters, last received byte, DUT pull-downs.
  int         n_tx = 0, n_done = 0, n_low = 0, n_long = 0;
  logic [7:0] last_recv = 8'h00;
  logic       prev_tx = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (tx_load) n_tx++;
    if (data_recv_done) begin
      n_done++;
      last_recv = data_recv;
    end
    if ((tx_load && prev_tx) || (data_recv_done && prev_done)) n_long++;
    prev_tx   = tx_load;
    prev_done = data_recv_done;
    if (!tb_sda_oe && sda == 1'b0) n_low++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    tb_sda_oe = 1'b0; qwait();
    scl_drv   = 1'b1; qwait();
    tb_sda_oe = 1'b1; qwait();
    scl_drv   = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    tb_sda_oe = 1'b1; qwait();
    scl_drv   = 1'b1; qwait();
    tb_sda_oe = 1'b0; qwait();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    tb_sda_oe = ~b; qwait();
    scl_drv   = 1'b1; qwait();
    s         = sda; qwait();
    scl_drv   = 1'b0; qwait();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack, input logic [7:0] nxt);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    data_send = nxt;
    bus_bit(nack, s);
  endtask

  // One transfer: address, then len bytes from dat (byte k = dat[8k+:8]).
  task automatic xfer(input string tag, input logic [6:0] a7, input logic rdn,
                      input int len, input logic [31:0] dat, input logic do_stop);
    logic       ack, match;
    logic [7:0] got, nxt;
    int         tx0, dn0, low0;
    match = (a7 == 7'h50);
    tx0 = n_tx; dn0 = n_done; low0 = n_low;
    if (rdn) data_send = dat[7:0];
    bus_start();
    wr_byte({a7, rdn}, ack);
    check({tag, "/addr_ack"}, ack, !match);
    check({tag, "/busy_addr"}, busy, match);
    if (match) begin
      check({tag, "/rw"}, rw, rdn);
      for (int k = 0; k < len; k++) begin
        if (!rdn) begin
          wr_byte(dat[8*k +: 8], ack);
          check({tag, "/data_ack"}, ack, 1'b0);
        end else begin
          nxt = (k < len - 1) ? dat[8*(k+1) +: 8] : 8'h00;
          rd_byte(got, (k == len - 1), nxt);
          check({tag, "/rd_byte"}, got, dat[8*k +: 8]);
        end
      end
      if (!rdn) begin
        check({tag, "/done_cnt"}, n_done - dn0, len);
        check({tag, "/data_recv"}, last_recv, dat[8*(len-1) +: 8]);
      end else begin
        check({tag, "/tx_cnt"}, n_tx - tx0, len);
        check({tag, "/sda_rel_nack"}, sda, 1'b1);
      end
      check({tag, "/busy_pre_stop"}, busy, 1'b1);
    end else begin
      check({tag, "/no_pull"}, n_low - low0, 0);
      check({tag, "/no_done"}, n_done - dn0, 0);
      check({tag, "/no_tx"}, n_tx - tx0, 0);
    end
    if (do_stop) begin
      bus_stop();
      check({tag, "/busy_stop"}, busy, 1'b0);
    end
  endtask

  initial begin
    logic       s;
    logic [7:0] got4;
    logic [6:0] a;
    logic       r;
    int         l;
    logic [31:0] d;

    // Reset state, checked while reset is held.
    repeat (4) @(negedge clk);
    check("rst/busy", busy, 1'b0);
    check("rst/rw", rw, 1'b0);
    check("rst/data_recv", data_recv, 8'h00);
    check("rst/done", data_recv_done, 1'b0);
    check("rst/tx_load", tx_load, 1'b0);
    check("rst/sda", sda, 1'b1);
    arst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed transfers.
    xfer("wr", 7'h50, 1'b0, 1, 32'h0000_005A, 1'b1);
    xfer("rd", 7'h50, 1'b1, 1, 32'h0000_00C3, 1'b1);
    xfer("burst", 7'h50, 1'b1, 3, 32'h0033_2211, 1'b1);
    xfer("mismatch", 7'h51, 1'b0, 1, 32'h0000_0000, 1'b1);
    xfer("rs_wr", 7'h50, 1'b0, 1, 32'h0000_0001, 1'b0);
    xfer("rs_rd", 7'h50, 1'b1, 1, 32'h0000_0096, 1'b1);
    check("rs/data_recv_kept", data_recv, 8'h01);

    // Reset asserted while bit 3 of a read byte (0xA5) is on the bus.
    data_send = 8'hA5;
    bus_start();
    wr_byte({7'h50, 1'b1}, s);
    check("rrst/addr_ack", s, 1'b0);
    for (int i = 7; i >= 4; i--) begin
      bus_bit(1'b1, s);
      got4[i] = s;
    end
    check("rrst/hi_nibble", got4[7:4], 4'hA);
    tb_sda_oe = 1'b0;
    @(negedge clk);
    check("rrst/bit3_low", sda, 1'b0);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("rrst/sda_rel", sda, 1'b1);
    check("rrst/busy", busy, 1'b0);
    check("rrst/rw", rw, 1'b0);
    check("rrst/data_recv", data_recv, 8'h00);
    check("rrst/tx_load", tx_load, 1'b0);
    repeat (3) @(negedge clk);
    arst = 1'b0;
    // Rest of the interrupted byte: the target must stay silent.
    l = n_low;
    for (int i = 3; i >= 0; i--) bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    check("rrst/silent", n_low - l, 0);
    bus_stop();
    check("rrst/busy_stop", busy, 1'b0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // 1-clk glitch on SDA mid-high of every data bit: no START/STOP seen.
    begin
      logic [7:0] gb;
      int dn0;
      gb = 8'h6C;
      bus_start();
      wr_byte({7'h50, 1'b0}, s);
      check("glitch/addr_ack", s, 1'b0);
      dn0 = n_done;
      for (int i = 7; i >= 0; i--) begin
        tb_sda_oe = ~gb[i]; qwait();
        scl_drv = 1'b1; qwait();
        tb_sda_oe = gb[i]; @(negedge clk);
        tb_sda_oe = ~gb[i];
        repeat (Q - 1) @(negedge clk);
        scl_drv = 1'b0; qwait();
      end
      bus_bit(1'b1, s);
      check("glitch/data_ack", s, 1'b0);
      check("glitch/busy", busy, 1'b1);
      check("glitch/done_cnt", n_done - dn0, 1);
      check("glitch/data_recv", last_recv, gb);
      bus_stop();
    end
`endif

    // Random transfers.
    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      r = 1'($urandom_range(0, 1));
      l = $urandom_range(1, 3);
      d = $urandom;
      xfer("rnd", a, r, l, d, 1'b1);
    end

    check("pulse_width", n_long, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this target answers to.
REQ-002 SHALL have port clk  input  1  system clock; SCL and SDA are oversampled on its rising edge.
REQ-003 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scl  input  1  I2C clock from the controller; this block never drives it.
REQ-005 SHALL have port sda  inout  1  open-drain data line: driven to 0 or released to high-Z, never driven to 1.
REQ-006 SHALL have port data_send  input  8  byte to transmit on a read; sampled when tx_load pulses.
REQ-007 SHALL have port tx_load  output  1  one-clk pulse marking the cycle data_send is captured.
REQ-008 SHALL have port data_recv  output  8  last byte received on a write.
REQ-009 SHALL have port data_recv_done  output  1  one-clk pulse; data_recv is valid in the same cycle.
REQ-010 SHALL have port rw  output  1  R/W bit of the last matched address byte (1 = read).
REQ-011 SHALL have port busy  output  1  high from an address match until STOP, or until a non-matching address byte.

Function
REQ-012 SHALL pass scl and sda each through a 2-flop synchronizer; all edge and condition detection uses the synchronized values.
REQ-013 SHALL require a clk frequency of at least 16x the SCL frequency (for example 50 MHz clk with 500 kHz SCL).
REQ-014 SHALL detect START as a synchronized sda falling edge while scl is high.
REQ-015 SHALL detect STOP as a synchronized sda rising edge while scl is high.
REQ-016 SHALL use states IDLE, ADDR, SACK1, WR, SACK2, RD, MACK.
REQ-017 On START in any state (repeated START included), the FSM SHALL go to ADDR, clear the bit counter and release sda.
REQ-018 On STOP in any state, the FSM SHALL go to IDLE, release sda and deassert busy.
REQ-019 In ADDR and WR, the block SHALL shift sda into a shift register MSB first on each scl rising edge and count 8 bits.
REQ-020 At the 8th address bit, if bits[7:1]==SLAVE_ADDR, the block SHALL set rw to bit[0], assert busy and go to SACK1.
REQ-021 At the 8th address bit with no address match, the block SHALL go to IDLE and ignore the bus until the next START.
REQ-022 In SACK1 and SACK2, the block SHALL drive sda low from the scl falling edge after the 8th bit until the next scl falling edge, then release it.
REQ-023 When SACK1 ends with rw=0, the FSM SHALL go to WR.
REQ-024 When SACK1 ends with rw=1, the block SHALL pulse tx_load, capture data_send and go to RD.
REQ-025 At the 8th WR bit, the block SHALL update data_recv and pulse data_recv_done within 1 clk of the synchronized scl rise, then go to SACK2.
REQ-026 When SACK2 ends, the FSM SHALL return to WR with the bit counter cleared.
REQ-027 In RD, on each scl falling edge the block SHALL present the next bit, MSB first: bit 0 drives sda low, bit 1 releases it. The first bit is presented at the falling edge that ends SACK1 or MACK.
REQ-028 After 8 RD bits, the block SHALL release sda and enter MACK; at the next scl rising edge it SHALL sample sda.
REQ-029 In MACK, an ACK (sda=0) SHALL pulse tx_load, load the next byte and return to RD at the following scl falling edge.
REQ-030 In MACK, a NACK (sda=1) SHALL send the FSM to IDLE, with sda released until STOP or START.
REQ-031 While scl is high, the block SHALL change its sda drive only on START or STOP detection; otherwise changes occur only after an scl falling edge.

Reset
REQ-032 While arst is asserted, the block SHALL hold state IDLE, data_recv=0, data_recv_done=0, tx_load=0, rw=0, busy=0, bit counter=0, sda released, and synchronizer flops=1.
REQ-033 A reset asserted mid-transfer SHALL release sda within the same clk cycle (asynchronous path) and ignore the bus until the next START.

Configuration
REQ-034 With macro I2C_SLAVE_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow each synchronizer; pulses of 1 clk or less are rejected and detection latency grows by 2 clk.
REQ-035 Without I2C_SLAVE_GLITCH_FILTER_EN, the synchronizer outputs SHALL be used directly, with no filter logic present.

Verification
REQ-036 Write: START, 0xA0, 0x5A, STOP -> ACK on both bytes; data_recv=0x5A with a 1-clk data_recv_done; busy falls at STOP.
REQ-037 Read: START, 0xA1, data_send=0xC3, controller NACK, STOP -> one tx_load pulse, bits 1100_0011 observed on sda, FSM in IDLE after NACK.
REQ-038 Burst read: START, 0xA1, controller ACK, ACK, NACK with data_send 0x11, 0x22, 0x33 -> three tx_load pulses and bytes in order.
REQ-039 Mismatch: START, 0xA2 -> sda never driven low, busy stays 0, no data_recv_done.
REQ-040 Repeated START: START, 0xA0, 0x01, START, 0xA1, read -> data_recv=0x01, then rw=1 and read data on the bus.
REQ-041 Reset asserted during RD bit 3 -> sda high-Z the same cycle and all outputs at reset values; with the filter enabled, a 1-clk SDA glitch while scl is high causes no START or STOP.
